// File: rtl/bsg_test_node_trace_master.sv
// -----------------------------------------------------------------------------
// bsg_test_node_trace_master
//
// Trace-driven master node on the FSB ring. Steps through an external trace
// ROM one entry per cycle at most:
//   DONE : finish the trace.
//   SEND : offer the payload to the client, with destid forced to dest_id_p.
//   RECV : accept one packet from the client and compare it (destid excluded).
//   WAIT : stall until every SEND has been answered by a RECV.
// An entry that is not DONE at the last ROM address ends the trace with
// error_o set. pc never wraps.
//
// Ports:
//   clk_i, reset_i      clock, synchronous active-high reset
//   en_i                start enable, sampled only in IDLE
//   v_i/data_i/ready_o  ring input from the client (valid/ready)
//   v_o/data_o/yumi_i   ring output to the client (valid/yumi)
//   rom_addr_o          trace pointer (pc)
//   rom_data_i          trace entry {op[1:0], payload}, combinational on pc
//   done_o              trace finished
//   error_o             sticky: mismatch seen or ROM overrun
//   error_cnt_o         saturating count of RECV mismatches
// -----------------------------------------------------------------------------
module bsg_test_node_trace_master #(
  parameter int          ring_width_p      = 80,
  parameter logic [3:0]  dest_id_p         = 4'h0,
  parameter int          rom_addr_width_p  = 10,
  parameter int          max_outstanding_p = 8,
  parameter int          err_cnt_width_p   = 16
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        en_i,
  input  logic                        v_i,
  input  logic [ring_width_p-1:0]     data_i,
  output logic                        ready_o,
  output logic                        v_o,
  output logic [ring_width_p-1:0]     data_o,
  input  logic                        yumi_i,
  output logic [rom_addr_width_p-1:0] rom_addr_o,
  input  logic [ring_width_p+1:0]     rom_data_i,
  output logic                        done_o,
  output logic                        error_o,
  output logic [err_cnt_width_p-1:0]  error_cnt_o
);

  localparam int out_width_lp = $clog2(max_outstanding_p + 1);
  localparam int cmp_width_lp = ring_width_p - 4;
  localparam logic [out_width_lp-1:0] max_out_lp = out_width_lp'(max_outstanding_p);

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_e;
  typedef enum logic [1:0] {
    OP_DONE = 2'b00,
    OP_SEND = 2'b01,
    OP_RECV = 2'b10,
    OP_WAIT = 2'b11
  } op_e;

  state_e                      r_state;
  state_e                      w_state_next;
  logic [rom_addr_width_p-1:0] r_pc;
  logic [out_width_lp-1:0]     r_outstanding;
  logic [err_cnt_width_p-1:0]  r_err_cnt;
  logic                        r_error;

  op_e                         w_op;
  logic [ring_width_p-1:0]     w_payload;
  logic                        w_exec;
  logic                        w_send_fire;
  logic                        w_recv_fire;
  logic                        w_wait_fire;
  logic                        w_retire;
  logic                        w_last;
  logic                        w_mismatch;
  logic                        w_unused;

  assign w_op      = op_e'(rom_data_i[ring_width_p+1:ring_width_p]);
  assign w_payload = rom_data_i[ring_width_p-1:0];
  assign w_exec    = (r_state == ST_EXEC);
  assign w_last    = (r_pc == '1);

  // Handshake outputs are gated by reset_i so an offer is withdrawn in the
  // reset cycle itself, not one cycle later. v_o never looks at yumi_i.
  assign v_o     = !reset_i && w_exec && (w_op == OP_SEND) && (r_outstanding < max_out_lp);
  assign ready_o = !reset_i && w_exec && (w_op == OP_RECV);
  assign data_o  = {dest_id_p, w_payload[cmp_width_lp-1:0]};

  assign w_send_fire = v_o && yumi_i;
  assign w_recv_fire = ready_o && v_i;
  assign w_wait_fire = w_exec && (w_op == OP_WAIT) && (r_outstanding == '0);
  assign w_retire    = w_send_fire || w_recv_fire || w_wait_fire;

  // Destid bits never take part in the compare.
  assign w_mismatch = (data_i[cmp_width_lp-1:0] != w_payload[cmp_width_lp-1:0]);
  assign w_unused   = ^{data_i[ring_width_p-1 -: 4], w_payload[ring_width_p-1 -: 4]};

  assign rom_addr_o  = r_pc;
  assign done_o      = (r_state == ST_DONE);
  assign error_o     = r_error;
  assign error_cnt_o = r_err_cnt;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  // NOTE: the next-state default is assigned first so no path leaves
  // w_state_next unassigned, which would infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (en_i) w_state_next = ST_EXEC;
      ST_EXEC: begin
        if (w_op == OP_DONE)        w_state_next = ST_DONE;
        else if (w_retire && w_last) w_state_next = ST_DONE;  // ROM overrun
      end
      ST_DONE: w_state_next = ST_DONE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_pc          <= '0;
      r_outstanding <= '0;
      r_err_cnt     <= '0;
      r_error       <= 1'b0;
    end else begin
      // The last entry still completes, but pc holds instead of wrapping.
      if (w_retire && !w_last) r_pc <= r_pc + rom_addr_width_p'(1);
      if (w_retire && w_last)  r_error <= 1'b1;

      // Only one op runs per cycle, so increment and decrement never collide.
      if (w_send_fire)
        r_outstanding <= r_outstanding + out_width_lp'(1);
      else if (w_recv_fire && (r_outstanding != '0))
        r_outstanding <= r_outstanding - out_width_lp'(1);

      if (w_recv_fire && w_mismatch) begin
        r_error <= 1'b1;
        if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + err_cnt_width_p'(1);
      end
    end
  end

endmodule

// File: tb/tb_bsg_test_node_trace_master.sv
// -----------------------------------------------------------------------------
// tb_bsg_test_node_trace_master
//
// Directed bench for bsg_test_node_trace_master with a 16-entry trace ROM,
// two credits of outstanding SENDs and a 2-bit mismatch counter so that
// saturation and ROM overrun are reachable in a few cycles. Expected values
// are written out by hand at each step.
// -----------------------------------------------------------------------------
module tb_bsg_test_node_trace_master;

  localparam int         RW   = 80;
  localparam logic [3:0] DEST = 4'hC;
  localparam int         AW   = 4;
  localparam int         MAXO = 2;
  localparam int         EW   = 2;

  localparam logic [1:0] OP_DONE = 2'b00;
  localparam logic [1:0] OP_SEND = 2'b01;
  localparam logic [1:0] OP_RECV = 2'b10;
  localparam logic [1:0] OP_WAIT = 2'b11;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic          en_i = 1'b0;
  logic          v_i = 1'b0;
  logic [RW-1:0] data_i = '0;
  logic          ready_o;
  logic          v_o;
  logic [RW-1:0] data_o;
  logic          yumi_i = 1'b0;
  logic [AW-1:0] rom_addr_o;
  logic [RW+1:0] rom_data_i;
  logic          done_o;
  logic          error_o;
  logic [EW-1:0] error_cnt_o;

  logic [RW+1:0] rom [16];
  assign rom_data_i = rom[rom_addr_o];

  int checks = 0;
  int errors = 0;

  bsg_test_node_trace_master #(
    .ring_width_p      (RW),
    .dest_id_p         (DEST),
    .rom_addr_width_p  (AW),
    .max_outstanding_p (MAXO),
    .err_cnt_width_p   (EW)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .en_i        (en_i),
    .v_i         (v_i),
    .data_i      (data_i),
    .ready_o     (ready_o),
    .v_o         (v_o),
    .data_o      (data_o),
    .yumi_i      (yumi_i),
    .rom_addr_o  (rom_addr_o),
    .rom_data_i  (rom_data_i),
    .done_o      (done_o),
    .error_o     (error_o),
    .error_cnt_o (error_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [RW+1:0] ent(input logic [1:0] op, input logic [RW-1:0] pl);
    return {op, pl};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = ent(OP_DONE, '0);
  endtask

  task automatic reset_dut();
    reset_i = 1'b1;
    en_i    = 1'b0;
    v_i     = 1'b0;
    yumi_i  = 1'b0;
    data_i  = '0;
    step();
    step();
    reset_i = 1'b0;
  endtask

  task automatic start();
    en_i = 1'b1;
    step();
    en_i = 1'b0;
    #1;
  endtask

  localparam logic [RW-1:0] P1      = 80'hF000_1111_2222_3333_00AB;
  localparam logic [RW-1:0] P1_OUT  = 80'hC000_1111_2222_3333_00AB;
  localparam logic [RW-1:0] P1_RET  = 80'h3000_1111_2222_3333_00AB;
  localparam logic [RW-1:0] EXP5    = 80'h0000_0000_0000_0000_0005;
  localparam logic [RW-1:0] BAD6    = 80'h9000_0000_0000_0000_0006;
  localparam logic [RW-1:0] DST5    = 80'h9000_0000_0000_0000_0005;

  initial begin
    clear_rom();

    // ---- Reset and idle: en_i low keeps everything quiet ----
    rom[0] = ent(OP_SEND, P1);
    rom[1] = ent(OP_RECV, P1);
    rom[2] = ent(OP_DONE, '0);
    reset_dut();
    for (int i = 0; i < 5; i++) step();
    chk("idle_v_o",     80'(v_o),        80'(0));
    chk("idle_ready_o", 80'(ready_o),    80'(0));
    chk("idle_done_o",  80'(done_o),     80'(0));
    chk("idle_pc",      80'(rom_addr_o), 80'(0));
    chk("idle_err",     80'(error_o),    80'(0));

    // ---- SEND with yumi stalled 3 cycles, RECV with destid-only diff, DONE ----
    start();
    chk("send_v_first", 80'(v_o), 80'(1));
    chk("send_data",    data_o,   P1_OUT);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("send_v_hold",    80'(v_o), 80'(1));
      chk("send_data_hold", data_o,   P1_OUT);
    end
    yumi_i = 1'b1;
    step();
    yumi_i = 1'b0;
    #1;
    chk("send_pc_adv",  80'(rom_addr_o), 80'(1));
    chk("recv_ready",   80'(ready_o),    80'(1));
    chk("recv_v_o_low", 80'(v_o),        80'(0));
    v_i    = 1'b1;
    data_i = P1_RET;
    step();
    v_i = 1'b0;
    #1;
    chk("recv_pc_adv", 80'(rom_addr_o), 80'(2));
    step();
    chk("done1_done",   80'(done_o),      80'(1));
    chk("done1_errcnt", 80'(error_cnt_o), 80'(0));
    chk("done1_err",    80'(error_o),     80'(0));
    en_i = 1'b1;
    step();
    step();
    en_i = 1'b0;
    chk("done1_hold",    80'(done_o),     80'(1));
    chk("done1_pc_hold", 80'(rom_addr_o), 80'(2));
    chk("done1_v_o",     80'(v_o),        80'(0));

    // ---- Outstanding limit: third SEND is held back ----
    clear_rom();
    rom[0] = ent(OP_SEND, 80'hA);
    rom[1] = ent(OP_SEND, 80'hB);
    rom[2] = ent(OP_SEND, 80'hC);
    rom[3] = ent(OP_RECV, 80'hA);
    reset_dut();
    start();
    yumi_i = 1'b1;
    chk("cred_v0", 80'(v_o), 80'(1));
    step();
    chk("cred_v1", 80'(v_o), 80'(1));
    step();
    chk("cred_v2_blocked", 80'(v_o),        80'(0));
    chk("cred_pc2",        80'(rom_addr_o), 80'(2));
    v_i    = 1'b1;
    data_i = 80'hA;
    for (int i = 0; i < 3; i++) step();
    chk("cred_pc_stall",  80'(rom_addr_o), 80'(2));
    chk("cred_v_stall",   80'(v_o),        80'(0));
    chk("cred_backpress", 80'(ready_o),    80'(0));
    yumi_i = 1'b0;
    v_i    = 1'b0;

    // ---- WAIT with one outstanding SEND stalls ----
    clear_rom();
    rom[0] = ent(OP_SEND, 80'h1);
    rom[1] = ent(OP_WAIT, '0);
    rom[2] = ent(OP_DONE, '0);
    reset_dut();
    start();
    yumi_i = 1'b1;
    step();
    yumi_i = 1'b0;
    v_i    = 1'b1;
    data_i = 80'h1;
    for (int i = 0; i < 4; i++) step();
    chk("wait_pc_stall", 80'(rom_addr_o), 80'(1));
    chk("wait_no_ready", 80'(ready_o),    80'(0));
    chk("wait_no_v_o",   80'(v_o),        80'(0));
    v_i = 1'b0;

    // ---- WAIT at zero outstanding, mismatches, destid-only diff, saturation ----
    clear_rom();
    rom[0] = ent(OP_WAIT, '0);
    for (int i = 1; i <= 5; i++) rom[i] = ent(OP_RECV, EXP5);
    rom[6] = ent(OP_DONE, '0);
    reset_dut();
    start();
    step();
    chk("wait0_adv", 80'(rom_addr_o), 80'(1));
    v_i    = 1'b1;
    data_i = BAD6;
    step();
    chk("mis_cnt1", 80'(error_cnt_o), 80'(1));
    chk("mis_err",  80'(error_o),     80'(1));
    data_i = DST5;
    step();
    chk("dst_only_cnt", 80'(error_cnt_o), 80'(1));
    data_i = BAD6;
    step();
    chk("mis_cnt2", 80'(error_cnt_o), 80'(2));
    step();
    step();
    v_i = 1'b0;
    chk("mis_cnt_sat", 80'(error_cnt_o), 80'(3));
    chk("mis_pc6",     80'(rom_addr_o),  80'(6));
    step();
    chk("mis_done",     80'(done_o),      80'(1));
    chk("mis_done_err", 80'(error_o),     80'(1));

    // ---- ROM overrun: no DONE anywhere, last entry completes then stops ----
    clear_rom();
    for (int i = 0; i < 14; i += 2) begin
      rom[i]   = ent(OP_SEND, 80'h77);
      rom[i+1] = ent(OP_RECV, 80'h77);
    end
    rom[14] = ent(OP_SEND, 80'h77);
    rom[15] = ent(OP_SEND, 80'h77);
    reset_dut();
    start();
    yumi_i = 1'b1;
    v_i    = 1'b1;
    data_i = 80'h77;
    for (int i = 0; i < 15; i++) step();
    chk("ovr_pc_last",  80'(rom_addr_o), 80'(15));
    chk("ovr_not_done", 80'(done_o),     80'(0));
    chk("ovr_v_last",   80'(v_o),        80'(1));
    step();
    chk("ovr_done", 80'(done_o), 80'(1));
    chk("ovr_err",  80'(error_o), 80'(1));
    step();
    step();
    chk("ovr_pc_hold", 80'(rom_addr_o),  80'(15));
    chk("ovr_v_o",     80'(v_o),         80'(0));
    chk("ovr_ready",   80'(ready_o),     80'(0));
    chk("ovr_errcnt",  80'(error_cnt_o), 80'(0));
    yumi_i = 1'b0;
    v_i    = 1'b0;

    // ---- Reset in the middle of a SEND ----
    clear_rom();
    rom[0] = ent(OP_RECV, EXP5);
    rom[1] = ent(OP_SEND, 80'h2);
    rom[2] = ent(OP_SEND, 80'h3);
    rom[3] = ent(OP_SEND, 80'h4);
    reset_dut();
    start();
    v_i    = 1'b1;
    data_i = BAD6;
    step();
    v_i = 1'b0;
    #1;
    chk("mid_err_set", 80'(error_o), 80'(1));
    yumi_i = 1'b1;
    step();
    yumi_i = 1'b0;
    #1;
    chk("mid_v_pending", 80'(v_o),        80'(1));
    chk("mid_pc2",       80'(rom_addr_o), 80'(2));
    reset_i = 1'b1;
    #1;
    chk("mid_v_drop", 80'(v_o), 80'(0));
    step();
    reset_i = 1'b0;
    #1;
    chk("mid_pc_clr",     80'(rom_addr_o),  80'(0));
    chk("mid_err_clr",    80'(error_o),     80'(0));
    chk("mid_errcnt_clr", 80'(error_cnt_o), 80'(0));
    step();
    chk("mid_idle_v",     80'(v_o),    80'(0));
    chk("mid_idle_ready", 80'(ready_o), 80'(0));
    // Outstanding was cleared: two fresh SENDs are allowed again.
    rom[0] = ent(OP_SEND, 80'h1);
    start();
    yumi_i = 1'b1;
    chk("mid_out_v0", 80'(v_o), 80'(1));
    step();
    chk("mid_out_v1", 80'(v_o), 80'(1));
    step();
    chk("mid_out_v2", 80'(v_o), 80'(0));
    yumi_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
